// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD constants, FSM state type and digit check
package bcd_pkg;

  localparam int         DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] digit);
    return digit <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcdadder.sv
// rtl/bcdadder.sv - combinational 1-digit BCD adder with carry in/out
module bcdadder (
  input  logic [3:0] num1,
  input  logic [3:0] num2,
  input  logic       cin,
  output logic [3:0] out,
  output logic       cout
);

  logic [4:0] raw;
  logic [4:0] adj;

  // Binary sums above 9 are corrected by +6 to wrap into the next decade.
  always_comb begin
    raw = {1'b0, num1} + {1'b0, num2} + {4'b0000, cin};
    adj = raw + 5'd6;
    if (raw > 5'd9) begin
      out  = adj[3:0];
      cout = 1'b1;
    end else begin
      out  = raw[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// rtl/bcd_serial_adder.sv - digit-serial multi-digit BCD adder, LSD first
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int W  = DIGIT_W * DIGITS;
  localparam int CW = $clog2(DIGITS) + 1;

  state_t          state;
  logic [W-1:0]    a_sh;
  logic [W-1:0]    b_sh;
  logic [W-1:0]    res_sh;
  logic [W+3:0]    res_ext;
  logic            carry;
  logic [CW-1:0]   cnt;
  logic            err_next;
  logic            err_in;
  logic [3:0]      add_out;
  logic            add_cout;

  bcdadder u_digit (
    .num1 (a_sh[3:0]),
    .num2 (b_sh[3:0]),
    .cin  (carry),
    .out  (add_out),
    .cout (add_cout)
  );

  // New digit enters at the top; after DIGITS shifts digit 0 sits at the bottom.
  assign res_ext = {add_out, res_sh};

  always_comb begin
    err_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd(a[i*DIGIT_W +: DIGIT_W]) || !is_bcd(b[i*DIGIT_W +: DIGIT_W]))
        err_in = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      err      <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      err_next <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh     <= a;
            b_sh     <= b;
            carry    <= cin;
            cnt      <= '0;
            err_next <= err_in;
            busy     <= 1'b1;
            state    <= ADD;
          end
        end
        ADD: begin
          res_sh <= res_ext[W+3:4];
          carry  <= add_cout;
          a_sh   <= a_sh >> DIGIT_W;
          b_sh   <= b_sh >> DIGIT_W;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(DIGITS - 1))
            state <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          sum   <= res_sh;
          cout  <= carry;
          err   <= err_next;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb/tb_bcd_serial_adder.sv - self-checking bench for bcd_serial_adder
module tb_bcd_serial_adder;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
    logic         chk_sum;
  } vec_t;

  vec_t tbl[6];

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] x);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(x[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // One start pulse; scrambles a/b/cin while busy to prove they were latched.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input logic [W-1:0] exp_sum, input logic exp_cout, input logic exp_err,
                        input logic chk_sum, input logic chk_hold, input logic [W-1:0] hold_sum);
    int k;
    int busy_cnt;
    bit seen;
    @(negedge clk);
    a = ta; b = tb_; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    k = 1; busy_cnt = 0; seen = 0;
    while (k <= 20 && !seen) begin
      if (busy) busy_cnt++;
      if (k == 3 && chk_hold) check("hold_sum", 32'(sum), 32'(hold_sum));
      if (done) seen = 1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    check("done_seen", 32'(seen), 1);
    check("latency", k, DIGITS + 2);
    check("busy_cycles", busy_cnt, DIGITS + 1);
    if (chk_sum) check("sum", 32'(sum), 32'(exp_sum));
    check("cout", 32'(cout), 32'(exp_cout));
    check("err", 32'(err), 32'(exp_err));
  endtask

  initial begin
    logic [W-1:0] ra, rb, prev, es;
    logic         rc;
    int           total;
    int           done_t[$];
    int           t;
    bit           saw;

    tbl[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{16'h00A0, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_sum", 32'(sum), 0);
    check("rst_cout", 32'(cout), 0);
    check("rst_err", 32'(err), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sum, tbl[i].cout, tbl[i].err,
             tbl[i].chk_sum, (i == 0) || tbl[(i == 0) ? 0 : i - 1].chk_sum,
             (i == 0) ? 16'h0000 : tbl[(i == 0) ? 0 : i - 1].sum);
    end

    // start held high: back-to-back operations every DIGITS+2 cycles
    @(negedge clk);
    a = 16'h0005; b = 16'h0005; cin = 1'b0; start = 1'b1;
    t = 0;
    while (t < 40 && done_t.size() < 3) begin
      @(negedge clk);
      t++;
      if (done) begin
        done_t.push_back(t);
        check("held_sum", 32'(sum), 32'h0010);
        check("held_cout", 32'(cout), 0);
      end
    end
    start = 1'b0;
    check("held_done_count", done_t.size(), 3);
    if (done_t.size() == 3) begin
      check("held_first", done_t[0], DIGITS + 2);
      check("held_period1", done_t[1] - done_t[0], DIGITS + 2);
      check("held_period2", done_t[2] - done_t[1], DIGITS + 2);
    end
    repeat (2) @(negedge clk);

    // reset asserted during the second ADD cycle abandons the operation
    a = 16'h4321; b = 16'h1111; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_sum", 32'(sum), 0);
    check("midrst_cout", 32'(cout), 0);
    check("midrst_err", 32'(err), 0);
    rst_n = 1'b1;
    saw = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) saw = 1;
    end
    check("midrst_no_done", 32'(saw), 0);

    prev = '0;
    for (int n = 0; n < 20; n++) begin
      for (int d = 0; d < DIGITS; d++) begin
        ra[d*4 +: 4] = 4'($urandom_range(0, 9));
        rb[d*4 +: 4] = 4'($urandom_range(0, 9));
      end
      rc = 1'($urandom);
      total = bcd2int(ra) + bcd2int(rb) + int'(rc);
      es = int2bcd(total % 10000);
      run_op(ra, rb, rc, es, total >= 10000, 1'b0, 1'b1, 1'b1, prev);
      prev = es;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
